muldiv_issue_ctrl: RTL and testbench
====================================

// Module: muldiv_issue_ctrl
// PURPOSE
//   Issue/retire controller between the control unit and the multi-cycle MULT and DIV cores.
//   Accepts MULT/DIV/MTHI/MTLO/CANCEL ops and launches the selected core.
//   Counts the core's fixed latency, then captures its hi/lo into the architectural
//   HI/LO registers. Interlocks MFHI/MFLO reads while an op is in flight.
// PARAMETERS
//   MULT_LAT  35  clocks from mult_init high until mult_hi/mult_lo are stable
//   DIV_LAT   35  clocks from div_init high until div_hi/div_lo are stable
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   reset, asynchronous, active-high
//   op_valid    in   1   op request strobe
//   op_code     in   3   001 MULT, 010 DIV, 011 MTHI, 100 MTLO, 101 CANCEL, others NOP
//   rs_val      in   32  operand A / MTHI-MTLO source
//   rt_val      in   32  operand B
//   rd_req      in   1   MFHI/MFLO pending in decode
//   busy        out  1   MULT/DIV in flight
//   stall       out  1   rd_req & busy (combinational)
//   done        out  1   1-cycle pulse: HI/LO updated by MULT/DIV
//   op_err      out  1   1-cycle pulse: non-CANCEL op dropped while busy
//   div0        out  1   1-cycle pulse: DIV by zero trapped (DIV0_TRAP_EN only, else tied 0)
//   mult_a/b    out  32  operands to mult core, held LAUNCH..CAPTURE
//   mult_init   out  1   1-cycle start pulse
//   mult_stop   out  1   1-cycle abort pulse
//   mult_hi/lo  in   32  mult core results
//   div_a/b, div_init, div_stop, div_hi/lo   same roles for div core
//   hi, lo      out  32  architectural HI/LO
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; HI/LO=0; operand regs 0; counter 0. Takes effect immediately.
//   FSM: IDLE -> LAUNCH -> WAIT -> CAPTURE -> IDLE.
//   IDLE: op_valid+MULT/DIV registers rs/rt into the core operands, sets unit select, goes LAUNCH.
//   IDLE: MTHI/MTLO writes hi/lo at the accepting edge. No busy, no done.
//   LAUNCH: selected *_init=1 for exactly 1 cycle; counter <= LAT-1; busy=1 from here.
//   WAIT: counter decrements each clock. At 0, goes to CAPTURE.
//   CAPTURE: hi<=core_hi, lo<=core_lo. Registered done=1 in the cycle the new HI/LO are visible.
//   CAPTURE: busy=0 in that same cycle. Returns to IDLE.
//   Latency: acceptance edge to done = LAT+2 clocks. Back-to-back op accepted the cycle done is high.
//   CANCEL in LAUNCH/WAIT/CAPTURE-entry: active *_stop=1 for 1 cycle, return IDLE, HI/LO unchanged.
//   CANCEL: no done; busy=0 next cycle. CANCEL in IDLE is a no-op.
//   Any other op while busy: dropped, op_err pulse; never queued.
//   Rst mid-op: abort silently; cores reset by their own rst. No stop pulse required.
//   Unused core's init/stop stay 0. Operands are 32-bit, passed unmodified (signed interpretation in cores).
// CONFIGURATION
//   DIV0_TRAP_EN defined: DIV with rt_val==0 is not launched.
//     Then div0 pulses the cycle after acceptance; HI/LO unchanged; no busy, no done.
//   DIV0_TRAP_EN undefined: DIV by zero runs normally; captured HI/LO = whatever div core outputs.
//     div0 tied 0.
// STRUCTURE
//   Package muldiv_pkg: op_code localparams and the FSM state typedef (IDLE/LAUNCH/WAIT/CAPTURE).
//   Package muldiv_pkg: default MULT_LAT/DIV_LAT.
//   Counter width $clog2(max(MULT_LAT,DIV_LAT)+1).
//   Sub-module hilo_regs: HI/LO storage; independent hi_we/lo_we plus joint capture write; reset 0.
// TESTING (behavioural core models honouring LAT)
//   MULT rs=7, rt=-3 (FFFFFFFD) -> done at +37 clocks; hi=FFFFFFFF, lo=FFFFFFEB; mult_init one pulse.
//   DIV rs=100, rt=7 -> done at +37; lo=0000000E, hi=00000002; mult_* untouched.
//   MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi/lo visible next cycle; busy stays 0.
//   MULT, CANCEL at WAIT counter=10 -> mult_stop 1 cycle; hi/lo keep prior; busy low next cycle; no done.
//   MULT, MTLO while busy -> op_err pulse, lo unchanged. rd_req=1 while busy -> stall=1; stall=0 with done.
//   rst mid-WAIT -> all outputs 0 immediately.
//   DIV rt=0 with DIV0_TRAP_EN -> div0 pulse, no div_init. Without macro -> normal 37-cycle op.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV issue controller: op encodings, FSM states,
// default core latencies and a small helper for sizing the latency counter.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT   = 3'b001;
  localparam logic [2:0] OP_DIV    = 3'b010;
  localparam logic [2:0] OP_MTHI   = 3'b011;
  localparam logic [2:0] OP_MTLO   = 3'b100;
  localparam logic [2:0] OP_CANCEL = 3'b101;

  localparam int unsigned MULT_LAT_DEF = 35;
  localparam int unsigned DIV_LAT_DEF  = 35;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair: independent MTHI/MTLO writes plus a joint
// capture write from the finishing core. Capture wins if both are asserted.
module hilo_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic [31:0] hi_wd,
  input  logic        lo_we,
  input  logic [31:0] lo_wd,
  input  logic        cap_we,
  input  logic [31:0] cap_hi,
  input  logic [31:0] cap_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_we) begin
      hi_d = cap_hi;
      lo_d = cap_lo;
    end else begin
      if (hi_we) hi_d = hi_wd;
      if (lo_we) lo_d = lo_wd;
    end
  end

  // NOTE: HI/LO are architectural state that software may read right after reset,
  // so they are reset to zero rather than left as uninitialised storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue/retire controller for the multi-cycle MULT and DIV cores.
// Optional feature: define DIV0_TRAP_EN to trap DIV by zero instead of launching it.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        op_err,
  output logic        div0,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_init,
  output logic        mult_stop,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_init,
  output logic        div_stop,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = $clog2(max_u(MULT_LAT, DIV_LAT) + 1);
  localparam logic [CNT_W-1:0] MULT_CNT_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT  = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_div_q, sel_div_d;
  logic [31:0]      mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [31:0]      div_a_q, div_a_d, div_b_q, div_b_d;
  logic             done_q, done_d;
  logic             op_err_q, op_err_d;
  logic             stop_q, stop_d;
`ifdef DIV0_TRAP_EN
  logic             div0_q, div0_d;
`endif

  logic is_cancel, is_real_op;
  logic hi_we, lo_we, cap_we;

  assign is_cancel  = op_valid && (op_code == OP_CANCEL);
  assign is_real_op = op_valid && (op_code inside {OP_MULT, OP_DIV, OP_MTHI, OP_MTLO});

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_div_d = sel_div_q;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    done_d    = 1'b0;
    op_err_d  = 1'b0;
    stop_d    = 1'b0;
`ifdef DIV0_TRAP_EN
    div0_d    = 1'b0;
`endif
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    cap_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT: begin
              mult_a_d  = rs_val;
              mult_b_d  = rt_val;
              sel_div_d = 1'b0;
              state_d   = LAUNCH;
            end
            OP_DIV: begin
`ifdef DIV0_TRAP_EN
              if (rt_val == '0) begin
                div0_d = 1'b1;
              end else
`endif
              begin
                div_a_d   = rs_val;
                div_b_d   = rt_val;
                sel_div_d = 1'b1;
                state_d   = LAUNCH;
              end
            end
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            default: ;
          endcase
        end
      end
      LAUNCH: begin
        cnt_d   = sel_div_q ? DIV_CNT_INIT : MULT_CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CAPTURE: begin
        cap_we  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A cancel overrides whatever the in-flight state would have done this cycle.
    if (state_q != IDLE) begin
      if (is_cancel) begin
        stop_d  = 1'b1;
        cap_we  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end else if (is_real_op) begin
        op_err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from
  // the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_div_q <= 1'b0;
      mult_a_q  <= '0;
      mult_b_q  <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      done_q    <= 1'b0;
      op_err_q  <= 1'b0;
      stop_q    <= 1'b0;
`ifdef DIV0_TRAP_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_div_q <= sel_div_d;
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      done_q    <= done_d;
      op_err_q  <= op_err_d;
      stop_q    <= stop_d;
`ifdef DIV0_TRAP_EN
      div0_q    <= div0_d;
`endif
    end
  end

  hilo_regs u_hilo_regs (
    .clk    (clk),
    .rst    (rst),
    .hi_we  (hi_we),
    .hi_wd  (rs_val),
    .lo_we  (lo_we),
    .lo_wd  (rs_val),
    .cap_we (cap_we),
    .cap_hi (sel_div_q ? div_hi : mult_hi),
    .cap_lo (sel_div_q ? div_lo : mult_lo),
    .hi     (hi),
    .lo     (lo)
  );

  assign busy      = (state_q != IDLE);
  assign stall     = rd_req & busy;
  assign done      = done_q;
  assign op_err    = op_err_q;
`ifdef DIV0_TRAP_EN
  assign div0      = div0_q;
`else
  assign div0      = 1'b0;
`endif
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign mult_init = (state_q == LAUNCH) && !sel_div_q;
  assign div_init  = (state_q == LAUNCH) &&  sel_div_q;
  assign mult_stop = stop_q && !sel_div_q;
  assign div_stop  = stop_q &&  sel_div_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl with behavioural MULT/DIV cores that
// only present valid results LAT clocks after their init pulse.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int MLAT = MULT_LAT_DEF;
  localparam int DLAT = DIV_LAT_DEF;
  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic        clk, rst;
  logic        op_valid, rd_req;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done, op_err, div0;
  logic [31:0] mult_a, mult_b, div_a, div_b, hi, lo;
  logic        mult_init, mult_stop, div_init, div_stop;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  muldiv_issue_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .rd_req(rd_req),
    .busy(busy), .stall(stall), .done(done), .op_err(op_err), .div0(div0),
    .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init), .mult_stop(mult_stop),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_a(div_a), .div_b(div_b), .div_init(div_init), .div_stop(div_stop),
    .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  // {hi = remainder, lo = quotient}; divide by zero yields {a, all-ones}.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    if (b == '0) return {a, 32'hFFFF_FFFF};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  // Behavioural cores: garbage until LAT clocks after init, cleared by stop/rst.
  logic [63:0] m_pend, d_pend;
  int m_rem, d_rem;
  always @(posedge clk or posedge rst) begin
    if (rst || mult_stop) begin
      m_rem <= 0; mult_hi <= GARB; mult_lo <= GARB;
    end else if (mult_init) begin
      m_pend <= mul64(mult_a, mult_b); m_rem <= MLAT - 1;
      mult_hi <= GARB; mult_lo <= GARB;
    end else if (m_rem == 1) begin
      {mult_hi, mult_lo} <= m_pend; m_rem <= 0;
    end else if (m_rem > 1) begin
      m_rem <= m_rem - 1;
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst || div_stop) begin
      d_rem <= 0; div_hi <= GARB; div_lo <= GARB;
    end else if (div_init) begin
      d_pend <= div64(div_a, div_b); d_rem <= DLAT - 1;
      div_hi <= GARB; div_lo <= GARB;
    end else if (d_rem == 1) begin
      {div_hi, div_lo} <= d_pend; d_rem <= 0;
    end else if (d_rem > 1) begin
      d_rem <= d_rem - 1;
    end
  end

  int n_mult_init = 0, n_div_init = 0;
  always @(negedge clk) begin
    if (mult_init) n_mult_init++;
    if (div_init)  n_div_init++;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.due));
          check("hi", 64'(hi), 64'(mon_e.hi));
          check("lo", 64'(lo), 64'(mon_e.lo));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
        check("done_missing", 64'(done), 64'd1);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.due = cyc + lat + 3;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; op is sampled at the next posedge; returns at the following negedge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
    @(negedge clk);
    op_valid = 1'b0; op_code = 3'b000;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("wait_done_timeout", 64'(done), 64'd1);
  endtask

  int c0, mi0, di0;
  logic [31:0] a_r, b_r;
  logic [63:0] r_exp;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({busy, stall, done, op_err, div0, mult_init, mult_stop, div_init, div_stop}), 64'd0);
    check("rst_mult_ops", {mult_a, mult_b}, 64'd0);
    check("rst_div_ops", {div_a, div_b}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULT 7 * -3
    mi0 = n_mult_init; di0 = n_div_init;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, MLAT);
    drive(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    check("launch_mult_init", 64'(mult_init), 64'd1);
    check("launch_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("wait_mult_init_low", 64'(mult_init), 64'd0);
    check("mult_operands", {mult_a, mult_b}, {32'd7, 32'hFFFF_FFFD});
    wait_done(100);
    check("mult_init_pulses", 64'(n_mult_init - mi0), 64'd1);
    check("mult_no_div_init", 64'(n_div_init - di0), 64'd0);

    // DIV 100 / 7 accepted back-to-back in the done cycle
    push_exp(32'h0000_0002, 32'h0000_000E, DLAT);
    drive(OP_DIV, 32'd100, 32'd7);
    wait_done(100);
    check("div_mult_ops_untouched", {mult_a, mult_b}, {32'd7, 32'hFFFF_FFFD});
    check("div_init_pulses", 64'(n_div_init - di0), 64'd1);
    check("div_no_mult_init", 64'(n_mult_init - mi0), 64'd1);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'(32'hDEAD_BEEF));
    check("mthi_busy", 64'(busy), 64'd0);
    op_code = OP_MTLO; rs_val = 32'h1234_5678;
    @(negedge clk);
    op_valid = 1'b0; op_code = 3'b000;
    check("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});
    check("mtlo_busy", 64'(busy), 64'd0);

    // MULT cancelled in WAIT with counter at 10
    c0 = cyc;
    drive(OP_MULT, 32'd5, 32'd6);
    rd_req = 1'b1;
    while (cyc < c0 + 26) @(negedge clk);
    check("cancel_pre_stall", 64'({busy, stall}), 64'b11);
    drive(OP_CANCEL, 32'd0, 32'd0);
    check("cancel_stop", 64'({mult_stop, div_stop}), 64'b10);
    check("cancel_busy_stall", 64'({busy, stall}), 64'b00);
    @(negedge clk);
    check("cancel_stop_1cyc", 64'(mult_stop), 64'd0);
    rd_req = 1'b0;
    repeat (40) @(negedge clk);
    check("cancel_hilo_kept", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

    // MTLO while busy is dropped; MFHI/MFLO stall until done
    push_exp(32'h0, 32'h0000_000C, MLAT);
    drive(OP_MULT, 32'd3, 32'd4);
    rd_req = 1'b1;
    repeat (3) @(negedge clk);
    drive(OP_MTLO, 32'hAAAA_5555, 32'd0);
    check("op_err_pulse", 64'(op_err), 64'd1);
    check("op_err_lo_kept", 64'(lo), 64'(32'h1234_5678));
    @(negedge clk);
    check("op_err_1cyc", 64'(op_err), 64'd0);
    check("stall_busy", 64'(stall), 64'd1);
    wait_done(100);
    check("stall_at_done", 64'(stall), 64'd0);
    rd_req = 1'b0;

    // Random back-to-back MULT/DIV mix
    for (int i = 0; i < 4; i++) begin
      a_r = $urandom;
      if (i % 2 == 1) begin
        b_r = 32'($urandom_range(1, 5000));
        if ($urandom_range(0, 1) == 1) b_r = -b_r;
        r_exp = div64(a_r, b_r);
        push_exp(r_exp[63:32], r_exp[31:0], DLAT);
        drive(OP_DIV, a_r, b_r);
      end else begin
        b_r = $urandom;
        r_exp = mul64(a_r, b_r);
        push_exp(r_exp[63:32], r_exp[31:0], MLAT);
        drive(OP_MULT, a_r, b_r);
      end
      wait_done(100);
    end

    // DIV by zero
    @(negedge clk);
    di0 = n_div_init;
    a_r = hi; b_r = lo;
`ifdef DIV0_TRAP_EN
    drive(OP_DIV, 32'd50, 32'd0);
    check("div0_pulse", 64'({div0, busy}), 64'b10);
    @(negedge clk);
    check("div0_1cyc", 64'(div0), 64'd0);
    repeat (3) @(negedge clk);
    check("div0_no_init", 64'(n_div_init - di0), 64'd0);
    check("div0_hilo_kept", {hi, lo}, {a_r, b_r});
`else
    push_exp(32'd50, 32'hFFFF_FFFF, DLAT);
    drive(OP_DIV, 32'd50, 32'd0);
    check("div0_tied_low", 64'(div0), 64'd0);
    wait_done(100);
    check("div0_init_pulses", 64'(n_div_init - di0), 64'd1);
`endif

    // Reset in the middle of WAIT
    @(negedge clk);
    drive(OP_MTHI, 32'h5555_0000, 32'd0);
    drive(OP_MULT, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ctrl", 64'({busy, done, op_err, mult_init, mult_stop, div_init, div_stop}), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_ops", {mult_a, mult_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(32'h0, 32'h0000_0006, MLAT);
    drive(OP_MULT, 32'd2, 32'd3);
    wait_done(100);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
